// File: rtl/if_fetch_pipe.sv
// Instruction fetch stage: issues in-order requests to the instruction SRAM bus, buffers responses
// and hands them to decode. The optional misaligned-PC exception is enabled by IF_ADEL_CHECK_EN.
module if_fetch_pipe #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
    parameter int          IBUF_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_br_or_jump_op,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [70:0] fs_to_ds_bus
);

    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;      // accepted, not yet returned (includes cancelled)
    logic [CW-1:0] cancel_cnt; // oldest outstanding responses to discard
    logic [CW-1:0] drop_cnt;   // responses still in flight from before the last reset
    logic [CW-1:0] occ;
    logic [PW-1:0] tag_wp, tag_rp, buf_wp, buf_rp;
    logic [31:0]   tag_mem [IBUF_DEPTH];
    logic [64:0]   buf_mem [IBUF_DEPTH];   // {ex, inst, pc}

    logic          redirect, accept, pop, push, wr_resp, dok_drop, dok_live;
    logic          fetch_ok, adel_push, room_outst, room_buf;
    logic [31:0]   redirect_pc;
    logic [64:0]   push_entry, head;
    logic [CW:0]   drop_sum;

    // Handshakes: a request transfers when inst_sram_req && inst_sram_addr_ok; a response
    // arrives with inst_sram_data_ok; an entry moves to decode when fs_to_ds_valid && ds_allowin.
    assign redirect    = ws_ex | ws_eret | br_taken;
    assign redirect_pc = ws_ex ? EX_ENTRY : (ws_eret ? cp0_epc : br_target);

    assign dok_drop = inst_sram_data_ok && (drop_cnt != '0);
    assign dok_live = inst_sram_data_ok && (drop_cnt == '0) && (outst != '0);
    assign wr_resp  = dok_live && (cancel_cnt == '0) && !redirect && !reset;

    assign room_outst = ({1'b0, outst} + {1'b0, drop_cnt}) < (CW+1)'(MAX_OUTST);
    assign room_buf   = ({1'b0, outst} + {1'b0, occ}) < (CW+1)'(IBUF_DEPTH);

`ifdef IF_ADEL_CHECK_EN
    logic adel_stop;
    logic pc_misaligned;
    assign pc_misaligned = fetch_pc[1:0] != 2'b00;
    assign fetch_ok      = !pc_misaligned && !adel_stop;
    // The exception entry waits for older responses so it stays in program order.
    assign adel_push     = pc_misaligned && !adel_stop && !reset && !redirect
                           && (outst == '0) && room_buf;

    always_ff @(posedge clk) begin
        if (reset || redirect) adel_stop <= 1'b0;
        else if (adel_push)    adel_stop <= 1'b1;
    end
`else
    assign fetch_ok  = 1'b1;
    assign adel_push = 1'b0;
`endif

    assign inst_sram_req   = !reset && !redirect && !br_stall && fetch_ok && room_outst && room_buf;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign accept     = inst_sram_req && inst_sram_addr_ok;
    assign push       = wr_resp || adel_push;
    assign push_entry = wr_resp ? {1'b0, inst_sram_rdata, tag_mem[tag_rp]} : {1'b1, 32'h0, fetch_pc};

    assign head           = buf_mem[buf_rp];
    assign fs_to_ds_valid = (occ != '0) && !redirect && !reset;
    assign pop            = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_bus   = {ds_br_or_jump_op, head[64], head[64] ? 5'h04 : 5'h00, head[63:0]};

    assign drop_sum = {1'b0, drop_cnt} + {1'b0, outst} - (CW+1)'(dok_drop) - (CW+1)'(dok_live);

    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wp] <= fetch_pc;
        if (push)   buf_mem[buf_wp] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            outst      <= '0;
            cancel_cnt <= '0;
            occ        <= '0;
            tag_wp     <= '0;
            tag_rp     <= '0;
            buf_wp     <= '0;
            buf_rp     <= '0;
            // Requests in flight across reset still answer later; remember how many to discard.
            drop_cnt   <= (drop_sum > (CW+1)'(MAX_OUTST)) ? CW'(MAX_OUTST) : drop_sum[CW-1:0];
        end else begin
            drop_cnt <= drop_cnt - CW'(dok_drop);
            outst    <= outst + CW'(accept) - CW'(dok_live);
            if (accept)   tag_wp <= tag_wp + PW'(1);
            if (dok_live) tag_rp <= tag_rp + PW'(1);
            if (redirect) begin
                fetch_pc   <= redirect_pc;
                cancel_cnt <= outst - CW'(dok_live);
                occ        <= '0;
                buf_wp     <= '0;
                buf_rp     <= '0;
            end else begin
                if (accept)                      fetch_pc   <= fetch_pc + 32'd4;
                if (dok_live && cancel_cnt != '0) cancel_cnt <= cancel_cnt - CW'(1);
                if (push) buf_wp <= buf_wp + PW'(1);
                if (pop)  buf_rp <= buf_rp + PW'(1);
                occ <= occ + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_pipe.sv
// Bench for if_fetch_pipe: bus responder, reference PC stream model and in-order scoreboard.
module tb_if_fetch_pipe;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin, br_stall, br_taken, ds_br_or_jump_op, ws_ex, ws_eret;
    logic [31:0] br_target, cp0_epc;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic        fs_to_ds_valid;
    logic [70:0] fs_to_ds_bus;

    if_fetch_pipe dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_stall(br_stall),
        .br_taken(br_taken), .br_target(br_target), .ds_br_or_jump_op(ds_br_or_jump_op),
        .ws_ex(ws_ex), .ws_eret(ws_eret), .cp0_epc(cp0_epc),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus(fs_to_ds_bus)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [69:0] exp_q[$];   // {ex, excode, inst, pc}
    logic [31:0] bus_q[$];   // accepted addresses awaiting data_ok
    logic [31:0] model_pc, model_fetch, first_pc;
    logic        model_halt, first_armed;
    logic        addr_ok_en, dok_en;
    int          n_deliv = 0;
    int          n_req = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h1234, ~pc[31:16]};
    endfunction

    function automatic void topup();
        while (!model_halt && exp_q.size() < 8) begin
`ifdef IF_ADEL_CHECK_EN
            if (model_pc[1:0] != 2'b00) begin
                exp_q.push_back({1'b1, 5'h04, 32'h0, model_pc});
                model_halt = 1'b1;
                continue;
            end
`endif
            exp_q.push_back({1'b0, 5'h00, mem_word(model_pc), model_pc});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc    = pc;
        model_fetch = pc;
        model_halt  = 1'b0;
        first_armed = 1'b1;
        topup();
    endfunction

    // One clock: drive bus inputs, sample outputs mid-cycle, update models, advance.
    task automatic cycle();
        logic redir;
        logic [31:0] tgt;
        inst_sram_addr_ok = addr_ok_en;
        inst_sram_data_ok = dok_en && (bus_q.size() != 0);
        inst_sram_rdata   = (bus_q.size() != 0) ? mem_word(bus_q[0]) : 32'h0;
        ds_br_or_jump_op  = 1'($urandom_range(0, 1));
        #1;
        redir = ws_ex | ws_eret | br_taken;
        tgt   = ws_ex ? EX_ENTRY : (ws_eret ? cp0_epc : br_target);
        if (reset) begin
            check("rst_req", 72'(inst_sram_req), 72'(0));
            check("rst_valid", 72'(fs_to_ds_valid), 72'(0));
        end else begin
            if (inst_sram_req) check("req_addr", 72'(inst_sram_addr), 72'(model_fetch));
            if (redir) check("redirect_valid", 72'(fs_to_ds_valid), 72'(0));
            if (fs_to_ds_valid && ds_allowin) begin
                n_deliv++;
                if (first_armed) begin
                    first_pc    = fs_to_ds_bus[31:0];
                    first_armed = 1'b0;
                end
                if (exp_q.size() == 0) check("unexpected_entry", 72'(1), 72'(0));
                else begin
                    check("entry", 72'(fs_to_ds_bus[69:0]), 72'(exp_q.pop_front()));
                    check("bd", 72'(fs_to_ds_bus[70]), 72'(ds_br_or_jump_op));
                end
            end
        end
        if (inst_sram_req && inst_sram_addr_ok) begin
            bus_q.push_back(inst_sram_addr);
            n_req++;
            model_fetch = model_fetch + 32'd4;
        end
        if (inst_sram_data_ok) void'(bus_q.pop_front());
        if (reset)      model_restart(RESET_PC);
        else if (redir) model_restart(tgt);
        else            topup();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int d0, r0;
        reset = 1'b1; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0; ws_ex = 1'b0;
        ws_eret = 1'b0; br_target = 32'h0; cp0_epc = 32'h0; ds_br_or_jump_op = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        addr_ok_en = 1'b0; dok_en = 1'b0;
        first_pc = 32'h0; first_armed = 1'b0;
        model_restart(RESET_PC);
        @(posedge clk);
        #1;
        run(3);
        check("const_bus", 72'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
              72'({1'b0, 2'b10, 4'b0, 32'h0}));

        // streaming: one entry per cycle from RESET_PC
        reset = 1'b0; addr_ok_en = 1'b1; dok_en = 1'b1;
        d0 = n_deliv;
        run(12);
        check("stream_count", 72'(n_deliv - d0), 72'(10));
        check("stream_first", 72'(first_pc), 72'(RESET_PC));

        // decode stall: buffer fills to depth, fetch stops, nothing lost
        ds_allowin = 1'b0;
        run(10);
        check("stall_req", 72'(inst_sram_req), 72'(0));
        addr_ok_en = 1'b0; ds_allowin = 1'b1;
        d0 = n_deliv;
        run(6);
        check("stall_drain", 72'(n_deliv - d0), 72'(4));

        // branch with two responses outstanding
        addr_ok_en = 1'b1; dok_en = 1'b0;
        run(2);
        check("outst_limit", 72'(bus_q.size()), 72'(2));
        check("outst_req", 72'(inst_sram_req), 72'(0));
        br_taken = 1'b1; br_target = 32'hbfc00100;
        cycle();
        br_taken = 1'b0; dok_en = 1'b1;
        run(12);
        check("br_first", 72'(first_pc), 72'(32'hbfc00100));

        // exception beats branch in the same cycle
        ws_ex = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00200;
        cycle();
        ws_ex = 1'b0; br_taken = 1'b0;
        run(10);
        check("ex_first", 72'(first_pc), 72'(EX_ENTRY));

        // eret (beats branch) to a misaligned epc
        ws_eret = 1'b1; cp0_epc = 32'hbfc00042; br_taken = 1'b1;
        cycle();
        ws_eret = 1'b0; br_taken = 1'b0;
        r0 = n_req;
        run(8);
        check("eret_first", 72'(first_pc), 72'(32'hbfc00042));
`ifdef IF_ADEL_CHECK_EN
        check("adel_noreq", 72'(n_req - r0), 72'(0));
`else
        check("eret_req", 72'(n_req - r0 > 0), 72'(1));
`endif
        ws_ex = 1'b1;
        cycle();
        ws_ex = 1'b0;
        run(6);

        // random traffic with occasional redirects
        for (int i = 0; i < 200; i++) begin
            addr_ok_en = 1'($urandom_range(0, 3) != 0);
            dok_en     = 1'($urandom_range(0, 3) != 0);
            ds_allowin = 1'($urandom_range(0, 3) != 0);
            br_stall   = 1'($urandom_range(0, 7) == 0);
            br_taken   = 1'($urandom_range(0, 24) == 0);
            br_target  = {16'hbfc0, 14'($urandom_range(0, 16383)), 2'b00};
            ws_ex      = 1'($urandom_range(0, 60) == 0);
            cycle();
        end
        br_taken = 1'b0; ws_ex = 1'b0; br_stall = 1'b0;
        ds_allowin = 1'b1; dok_en = 1'b1; addr_ok_en = 1'b0;
        run(8);

        // reset with one request outstanding; its response returns after release
        addr_ok_en = 1'b1; dok_en = 1'b0;
        cycle();
        addr_ok_en = 1'b0;
        check("pre_rst_outst", 72'(bus_q.size()), 72'(1));
        reset = 1'b1;
        run(2);
        reset = 1'b0; addr_ok_en = 1'b1;
        run(2);
        dok_en = 1'b1;
        d0 = n_deliv;
        run(10);
        check("rst_first", 72'(first_pc), 72'(RESET_PC));
        check("rst_deliv", 72'(n_deliv - d0 > 0), 72'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
